// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants, FSM state type and frame-width helper for spi_reg_peripheral
package spi_reg_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// rtl/spi_reg_peripheral_if.sv - SPI pin bundle between controller and register peripheral
interface spi_reg_peripheral_if;

  logic nCS;
  logic SCLK;
  logic COPI;
  logic cipo;
  logic cipo_oe;

  modport master (
    output nCS,
    output SCLK,
    output COPI,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  nCS,
    input  SCLK,
    input  COPI,
    output cipo,
    output cipo_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulses for one async pin
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 read/write register bank; SPI_ERR_CNT_EN adds err_cnt
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_peripheral_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
`ifdef SPI_ERR_CNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_ADDR_END  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_W + 1);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(spi.nCS),
    .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi.SCLK),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(spi.COPI),
    .dout(copi_s), .rise(copi_rise), .fall(copi_fall)
  );
  assign unused_sync = &{1'b0, sclk_s, copi_rise, copi_fall};

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   shift_in;
  logic [DATA_W-1:0]    rd_shift;
  logic [DATA_W-1:0]    rd_word;
  logic                 rd_load_q;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  logic                 f_rw;
  logic [ADDR_W-1:0]    f_addr;
  logic [DATA_W-1:0]    f_data;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 addr_ok;
  logic                 commit;
  logic                 bit_sample;

  assign f_rw       = shift_in[FRAME_W-1];
  assign f_addr     = shift_in[DATA_W +: ADDR_W];
  assign f_data     = shift_in[DATA_W-1:0];
  assign rd_addr    = shift_in[ADDR_W-1:0];
  assign addr_ok    = int'(f_addr) < NUM_REGS;
  assign commit     = ncs_rise && (cnt == CNT_FRAME) && (f_rw == RW_WRITE) && addr_ok;
  // nCS edges take priority, so an SCLK edge landing with them is dropped
  assign bit_sample = sclk_rise && !ncs_fall && !ncs_rise && (state != IDLE);

`ifdef SPI_ERR_CNT_EN
  localparam bit ERR_READABLE = ((2 ** ADDR_W) - 1) >= NUM_REGS;
  logic [7:0] err_q;
  logic       reject;

  assign reject  = (cnt != CNT_FRAME) || ((f_rw == RW_WRITE) && !addr_ok);
  assign err_cnt = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (ncs_rise && reject && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = regs[i];
    end
`ifdef SPI_ERR_CNT_EN
    if (ERR_READABLE && (rd_addr == '1)) rd_word = DATA_W'(err_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ncs_rise) begin
      state_nx = IDLE;
    end else if (ncs_fall) begin
      state_nx = ADDR;
    end else if (bit_sample) begin
      case (state)
        ADDR:    if (cnt == CNT_LAST_ADDR) state_nx = DATA;
        DATA:    if (cnt == CNT_LAST_DATA) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shift_in  <= '0;
      rd_shift  <= '0;
      rd_load_q <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_load_q <= 1'b0;
      if (ncs_fall) begin
        cnt      <= '0;
        shift_in <= '0;
        rd_shift <= '0;
      end else if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (f_addr == ADDR_W'(i)) regs[i] <= f_data;
        end
        wr_strobe <= 1'b1;
        wr_addr   <= f_addr;
      end else if (bit_sample) begin
        shift_in <= {shift_in[FRAME_W-2:0], copi_s};
        if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST_ADDR) rd_load_q <= 1'b1;
      end
      // MSB is held through the falling edge that ends the address phase
      if (rd_load_q) begin
        rd_shift <= rd_word;
      end else if (sclk_fall && (state == DATA) && (cnt > CNT_ADDR_END)) begin
        rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign spi.cipo    = (state == DATA) ? rd_shift[DATA_W-1] : 1'b0;
  assign spi.cipo_oe = ~ncs_s;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - directed frames against a transaction-level model of the register bank
module tb_spi_reg_peripheral;
  import spi_reg_pkg::*;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int SYNC     = 2;
  localparam int H        = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_peripheral_if spi ();
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
`ifdef SPI_ERR_CNT_EN
  logic [7:0]                 err_cnt;
`endif

  spi_reg_peripheral #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi),
    .regs_out(regs_out),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr)
`ifdef SPI_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_strobes = 0;

  // Model: register contents and the effect of each finished frame, applied SYNC+1 clocks after nCS rises
  logic [7:0] m_regs [NUM_REGS];
  logic       m_strobe;
  logic [6:0] m_wr_addr;
  int         m_err;
  int         pend = 0;
  bit         pend_commit, pend_rej;
  logic [6:0] pend_addr;
  logic [7:0] pend_data;
  logic       ncs_pipe [SYNC];
  logic [7:0] rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic rw, input logic [6:0] a, input logic [7:0] d);
    return {rw, a, d};
  endfunction

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    if (a < 7'(NUM_REGS)) return m_regs[a[2:0]];
`ifdef SPI_ERR_CNT_EN
    if (a == 7'h7F) return m_err[7:0];
`endif
    return 8'h00;
  endfunction

  function automatic logic [63:0] exp_regs();
    logic [63:0] e;
    for (int i = 0; i < NUM_REGS; i++) e[i*8 +: 8] = m_regs[i];
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < SYNC; i++) ncs_pipe[i] = 1'b1;
      m_strobe = 1'b0;
      m_wr_addr = 7'h00;
      m_err = 0;
      pend = 0;
    end else begin
      for (int i = SYNC - 1; i > 0; i--) ncs_pipe[i] = ncs_pipe[i-1];
      ncs_pipe[0] = spi.nCS;
      m_strobe = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_commit) begin
            m_regs[pend_addr[2:0]] = pend_data;
            m_strobe = 1'b1;
            m_wr_addr = pend_addr;
          end
          if (pend_rej && m_err < 255) m_err++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("regs_out", regs_out, exp_regs());
      check("wr_strobe", wr_strobe, m_strobe);
      check("wr_addr", wr_addr, m_wr_addr);
      check("cipo_oe", spi.cipo_oe, !ncs_pipe[SYNC-1]);
      if (ncs_pipe[SYNC-1] === 1'b1) check("cipo_idle", spi.cipo, 1'b0);
`ifdef SPI_ERR_CNT_EN
      check("err_cnt", err_cnt, m_err[7:0]);
`endif
      if (wr_strobe === 1'b1) n_strobes++;
    end
  end

  task automatic spi_frame(input logic [15:0] frame, input int nbits, output logic [7:0] rdv,
                           input bit rst_abort, input int gap);
    logic [15:0] sh;
    sh = frame;
    rdv = 8'h00;
    @(negedge clk);
    spi.nCS = 1'b0;
    spi.SCLK = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.COPI = sh[15];
      sh = sh << 1;
      repeat (H) @(negedge clk);
      if (i >= 8 && i < 16) rdv = {rdv[6:0], spi.cipo};
      spi.SCLK = 1'b1;
      repeat (H) @(negedge clk);
      spi.SCLK = 1'b0;
    end
    repeat (H) @(negedge clk);
    if (rst_abort) begin
      rst_n = 1'b0;
      spi.nCS = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      spi.nCS = 1'b1;
      pend_commit = (nbits == 16) && (frame[15] == RW_WRITE) && (frame[14:8] < 7'(NUM_REGS));
      pend_rej    = (nbits != 16) || ((frame[15] == RW_WRITE) && (frame[14:8] >= 7'(NUM_REGS)));
      pend_addr   = frame[14:8];
      pend_data   = frame[7:0];
      pend        = SYNC + 1;
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    spi.nCS = 1'b1;
    spi.SCLK = 1'b0;
    spi.COPI = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_regs", regs_out, 64'h0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_cipo", spi.cipo, 1'b0);
    check("rst_cipo_oe", spi.cipo_oe, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    spi_frame(mk(RW_WRITE, 7'h02, 8'hA5), 16, rd, 1'b0, 32);
    check("t1_regs", regs_out, 64'h0000_0000_00A5_0000);
    check("t1_wr_addr", wr_addr, 7'h02);
    check("t1_strobes", n_strobes, 1);

    spi_frame(mk(RW_WRITE, 7'h04, 8'h3C), 16, rd, 1'b0, 32);
    spi_frame(mk(RW_READ, 7'h04, 8'h00), 16, rd, 1'b0, 32);
    check("t2_read_lit", rd, 8'h3C);
    check("t2_read_model", rd, exp_read(7'h04));
    check("t2_strobes", n_strobes, 2);

    spi_frame(mk(RW_WRITE, 7'h05, 8'h77), 15, rd, 1'b0, 32);
    check("t3_short_regs", regs_out, 64'h0000_003C_00A5_0000);
    check("t3_short_strobes", n_strobes, 2);
    spi_frame(mk(RW_WRITE, 7'h03, 8'h99), 17, rd, 1'b0, 32);
    check("t3_long_regs", regs_out, 64'h0000_003C_00A5_0000);
`ifdef SPI_ERR_CNT_EN
    check("t3_err_lit", err_cnt, 8'd2);
`endif

    spi_frame(mk(RW_WRITE, 7'h10, 8'hFF), 16, rd, 1'b0, 32);
    check("t4_oor_regs", regs_out, 64'h0000_003C_00A5_0000);
    check("t4_oor_strobes", n_strobes, 2);
    spi_frame(mk(RW_READ, 7'h10, 8'h00), 16, rd, 1'b0, 32);
    check("t4_oor_read", rd, 8'h00);
`ifdef SPI_ERR_CNT_EN
    spi_frame(mk(RW_READ, 7'h7F, 8'h00), 16, rd, 1'b0, 32);
    check("t4_err_read", rd, 8'd3);
`endif

    spi_frame(mk(RW_WRITE, 7'h01, 8'h55), 9, rd, 1'b1, 8);
    check("t5_rst_regs", regs_out, 64'h0);
    check("t5_rst_wr_addr", wr_addr, 7'h00);
    check("t5_rst_cipo_oe", spi.cipo_oe, 1'b0);
    spi_frame(mk(RW_WRITE, 7'h01, 8'h55), 16, rd, 1'b0, 32);
    check("t5_regs", regs_out, 64'h0000_0000_0000_5500);
    check("t5_wr_addr", wr_addr, 7'h01);

    spi_frame(mk(RW_WRITE, 7'h00, 8'h11), 16, rd, 1'b0, 0);
    spi_frame(mk(RW_WRITE, 7'h01, 8'h22), 16, rd, 1'b0, 32);
    check("t6_regs", regs_out, 64'h0000_0000_0000_2211);
    check("t6_wr_addr", wr_addr, 7'h01);
    check("t6_strobes", n_strobes, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
